branch_unit_ras: RTL and testbench

- Parametrised next-generation branch/control-flow unit for the RISC core's execute stage.
- Resolves B, BL, BLX, BX, conditional branch, CBZ/CBNZ, RET and NOP with a valid/ready handshake.
- Evaluates a full 16-entry condition set against NZCV flags and holds return addresses in a return-address stack (RAS).
- Provides a breakpoint HALT state with explicit resume.

---
 rtl/branch_pkg.sv | 66 ++++++
 rtl/ras_stack.sv | 55 +++++
 rtl/branch_unit_ras.sv | 158 +++++++++++++++
 tb/tb_branch_unit_ras.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// ============================================================================
// Module  : branch_pkg
// Purpose : Shared encodings and condition evaluation for branch_unit_ras.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_B     = 4'd1,
    OP_BL    = 4'd2,
    OP_BLX   = 4'd3,
    OP_BX    = 4'd4,
    OP_BCOND = 4'd5,
    OP_CBZ   = 4'd6,
    OP_CBNZ  = 4'd7,
    OP_RET   = 4'd8
  } op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Flags are packed {N,Z,C,V}.
  function automatic logic cond_met(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    r  = 1'b0;
    case (c)
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_CS: r = cy;
      COND_CC: r = !cy;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = cy && !z;
      COND_LS: r = !cy || z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = !z && (n == v);
      COND_LE: r = z || (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
// Module  : ras_stack
// Purpose : Circular return-address stack; a push when full drops the oldest.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_sp;
  logic [CW-1:0]    r_count;

  // r_sp addresses the next free slot, so it wraps onto the oldest entry when full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (push) begin
      r_sp <= r_sp + PW'(1);
      if (r_count != CW'(DEPTH))
        r_count <= r_count + CW'(1);
    end else if (pop) begin
      r_sp    <= r_sp - PW'(1);
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      r_mem[r_sp] <= din;
  end

  assign dout  = r_mem[r_sp - PW'(1)];
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/branch_unit_ras.sv
// ============================================================================
// Module  : branch_unit_ras
// Purpose : Execute-stage branch resolver with RAS and breakpoint HALT.
//           Optional branch trace outputs when BRANCH_TRACE_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_unit_ras
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RAS_DEPTH   = 4,
  parameter int INSTR_BYTES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [3:0]      op,
  input  logic [3:0]      cond,
  input  logic [3:0]      flags,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] reg_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            bkpt_en,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] lr_out,
  output logic            taken,
  output logic            valid_out,
  output logic            halted,
  output logic            ras_overflow,
  output logic            ras_underflow
`ifdef BRANCH_TRACE_EN
  ,
  output logic [XLEN-1:0] trace_src,
  output logic [XLEN-1:0] trace_dst,
  output logic [31:0]     trace_cnt
`endif
);

  state_e r_state, w_state_next;

  logic            w_accept, w_exec;
  logic [XLEN-1:0] w_seq, w_tgt, w_reg_pc, w_pc_next, w_ras_dout;
  logic            w_taken, w_push, w_pop, w_uflow;
  logic            w_ras_empty, w_ras_full;

  assign w_accept = valid_in && ready_out;
  assign w_exec   = w_accept && !bkpt_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (w_accept && bkpt_en) w_state_next = ST_HALT;
      ST_HALT: if (resume)              w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    ready_out = (r_state == ST_RUN);
    halted    = (r_state == ST_HALT);
  end

  always_comb begin
    w_seq     = pc_in + XLEN'(INSTR_BYTES);
    w_tgt     = pc_in + imm_in;
    w_reg_pc  = {reg_in[XLEN-1:1], 1'b0};
    w_pc_next = w_seq;
    w_taken   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_uflow   = 1'b0;
    case (op)
      OP_B:     begin w_pc_next = w_tgt; w_taken = 1'b1; end
      OP_BL:    begin w_pc_next = w_tgt; w_taken = 1'b1; w_push = 1'b1; end
      OP_BLX:   begin w_pc_next = w_reg_pc; w_taken = 1'b1; w_push = 1'b1; end
      OP_BX:    begin w_pc_next = w_reg_pc; w_taken = 1'b1; end
      OP_BCOND: if (cond_met(cond, flags)) begin w_pc_next = w_tgt; w_taken = 1'b1; end
      OP_CBZ:   if (reg_in == '0) begin w_pc_next = w_tgt; w_taken = 1'b1; end
      OP_CBNZ:  if (reg_in != '0) begin w_pc_next = w_tgt; w_taken = 1'b1; end
      OP_RET: begin
        w_taken = 1'b1;
        if (!w_ras_empty) begin
          w_pop     = 1'b1;
          w_pc_next = w_ras_dout;
        end else begin
          w_pc_next = w_reg_pc;
          w_uflow   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (XLEN)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (w_exec && w_push),
    .pop   (w_exec && w_pop),
    .din   (w_seq),
    .dout  (w_ras_dout),
    .empty (w_ras_empty),
    .full  (w_ras_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out        <= '0;
      lr_out        <= '0;
      taken         <= 1'b0;
      valid_out     <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      valid_out <= w_accept;
      if (w_accept && bkpt_en) begin
        pc_out <= pc_in;
        taken  <= 1'b0;
      end else if (w_exec) begin
        pc_out <= w_pc_next;
        taken  <= w_taken;
        if (w_push) begin
          lr_out <= w_seq;
          if (w_ras_full) ras_overflow <= 1'b1;
        end
        if (w_uflow) ras_underflow <= 1'b1;
      end
    end
  end

`ifdef BRANCH_TRACE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_src <= '0;
      trace_dst <= '0;
      trace_cnt <= '0;
    end else if (w_exec && w_taken) begin
      trace_src <= pc_in;
      trace_dst <= w_pc_next;
      trace_cnt <= trace_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_unit_ras.sv
// ============================================================================
// Module  : tb_branch_unit_ras
// Purpose : Directed self-checking bench for branch_unit_ras.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_unit_ras;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [3:0]  op = 4'd0, cond = 4'd0, flags = 4'd0;
  logic [31:0] pc_in = '0, reg_in = '0, imm_in = '0;
  logic        bkpt_en = 1'b0, resume = 1'b0;
  logic [31:0] pc_out, lr_out;
  logic        taken, valid_out, halted, ras_overflow, ras_underflow;
`ifdef BRANCH_TRACE_EN
  logic [31:0] trace_src, trace_dst, trace_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_unit_ras #(.XLEN(32), .RAS_DEPTH(4), .INSTR_BYTES(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .op(op), .cond(cond), .flags(flags), .pc_in(pc_in), .reg_in(reg_in),
    .imm_in(imm_in), .bkpt_en(bkpt_en), .resume(resume), .pc_out(pc_out),
    .lr_out(lr_out), .taken(taken), .valid_out(valid_out), .halted(halted),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
`ifdef BRANCH_TRACE_EN
    , .trace_src(trace_src), .trace_dst(trace_dst), .trace_cnt(trace_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction for one cycle; returns #1 after the capturing edge.
  task automatic issue(input logic [3:0] o, input logic [3:0] c, input logic [3:0] f,
                       input logic [31:0] pc, input logic [31:0] r, input logic [31:0] imm);
    valid_in = 1'b1; op = o; cond = c; flags = f; pc_in = pc; reg_in = r; imm_in = imm;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  logic [31:0] exp_ret [5];

  initial begin
    // Reset state
    idle(); idle();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_lr", lr_out, 32'h0);
    chk("rst_taken", {31'b0, taken}, 32'h0);
    chk("rst_vout", {31'b0, valid_out}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_ovf", {31'b0, ras_overflow}, 32'h0);
    chk("rst_uflow", {31'b0, ras_underflow}, 32'h0);
    reset = 1'b0;
    idle();
    chk("rst_ready", {31'b0, ready_out}, 32'h1);

    // Conditional branches
    issue(OP_BCOND, COND_EQ, 4'b0100, 32'h100, 32'h0, 32'h20);
    chk("eq_t_pc", pc_out, 32'h120);
    chk("eq_t_taken", {31'b0, taken}, 32'h1);
    chk("eq_t_vout", {31'b0, valid_out}, 32'h1);
    idle();
    chk("hold_vout", {31'b0, valid_out}, 32'h0);
    chk("hold_pc", pc_out, 32'h120);
    issue(OP_BCOND, COND_EQ, 4'b0000, 32'h100, 32'h0, 32'h20);
    chk("eq_nt_pc", pc_out, 32'h104);
    chk("eq_nt_taken", {31'b0, taken}, 32'h0);
    issue(OP_BCOND, COND_GT, 4'b1001, 32'h100, 32'h0, 32'h40);
    chk("gt_pc", pc_out, 32'h140);
    issue(OP_BCOND, COND_LS, 4'b0010, 32'h100, 32'h0, 32'h40);
    chk("ls_pc", pc_out, 32'h104);
    issue(OP_BCOND, COND_NV, 4'b1111, 32'h100, 32'h0, 32'h40);
    chk("nv_taken", {31'b0, taken}, 32'h0);

    // CBZ / CBNZ / undefined op
    issue(OP_CBZ, 4'd0, 4'd0, 32'h500, 32'h0, 32'h10);
    chk("cbz_pc", pc_out, 32'h510);
    issue(OP_CBNZ, 4'd0, 4'd0, 32'h500, 32'h0, 32'h10);
    chk("cbnz_pc", pc_out, 32'h504);
    issue(4'd12, 4'd0, 4'd0, 32'h600, 32'h0, 32'h10);
    chk("undef_pc", pc_out, 32'h604);
    chk("undef_taken", {31'b0, taken}, 32'h0);

    // BL then RET
    issue(OP_BL, 4'd0, 4'd0, 32'h200, 32'h0, 32'h40);
    chk("bl_lr", lr_out, 32'h204);
    chk("bl_pc", pc_out, 32'h240);
    issue(OP_RET, 4'd0, 4'd0, 32'h240, 32'h0, 32'h0);
    chk("ret_pc", pc_out, 32'h204);
    chk("ret_taken", {31'b0, taken}, 32'h1);

    // RAS overflow and underflow
    for (int i = 0; i < 5; i++) begin
      issue(OP_BL, 4'd0, 4'd0, 32'(i * 16), 32'h0, 32'h1000);
      if (i == 3) chk("ovf_before", {31'b0, ras_overflow}, 32'h0);
    end
    chk("ovf_set", {31'b0, ras_overflow}, 32'h1);
    exp_ret[0] = 32'h44; exp_ret[1] = 32'h34; exp_ret[2] = 32'h24; exp_ret[3] = 32'h14;
    exp_ret[4] = 32'h1234;
    for (int i = 0; i < 5; i++) begin
      issue(OP_RET, 4'd0, 4'd0, 32'h2000, 32'h1235, 32'h0);
      chk($sformatf("ret%0d_pc", i), pc_out, exp_ret[i]);
      if (i == 3) chk("uflow_before", {31'b0, ras_underflow}, 32'h0);
    end
    chk("uflow_set", {31'b0, ras_underflow}, 32'h1);

    // Breakpoint HALT and resume
    bkpt_en = 1'b1;
    issue(OP_B, 4'd0, 4'd0, 32'h300, 32'h0, 32'h50);
    bkpt_en = 1'b0;
    chk("bkpt_pc", pc_out, 32'h300);
    chk("bkpt_taken", {31'b0, taken}, 32'h0);
    chk("bkpt_vout", {31'b0, valid_out}, 32'h1);
    chk("bkpt_halted", {31'b0, halted}, 32'h1);
    chk("bkpt_ready", {31'b0, ready_out}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      issue(OP_B, 4'd0, 4'd0, 32'h700, 32'h0, 32'h8);
      chk("halt_vout", {31'b0, valid_out}, 32'h0);
      chk("halt_pc", pc_out, 32'h300);
    end
    resume = 1'b1;
    idle();
    resume = 1'b0;
    chk("resume_halted", {31'b0, halted}, 32'h0);
    chk("resume_ready", {31'b0, ready_out}, 32'h1);
    issue(OP_B, 4'd0, 4'd0, 32'h400, 32'h0, 32'h8);
    chk("after_resume_pc", pc_out, 32'h408);
    chk("after_resume_vout", {31'b0, valid_out}, 32'h1);

    // Wrap-around and BX alignment
    issue(OP_B, 4'd0, 4'd0, 32'hFFFF_FFF0, 32'h0, 32'h20);
    chk("wrap_pc", pc_out, 32'h10);
    issue(OP_BX, 4'd0, 4'd0, 32'h100, 32'h8001, 32'h0);
    chk("bx_pc", pc_out, 32'h8000);
    issue(OP_BLX, 4'd0, 4'd0, 32'h900, 32'h3333, 32'h0);
    chk("blx_pc", pc_out, 32'h3332);
    chk("blx_lr", lr_out, 32'h904);

    // Asynchronous reset mid-HALT with a partly filled RAS
    issue(OP_BL, 4'd0, 4'd0, 32'hA00, 32'h0, 32'h10);
    bkpt_en = 1'b1;
    issue(OP_NOP, 4'd0, 4'd0, 32'hB00, 32'h0, 32'h0);
    bkpt_en = 1'b0;
    chk("pre_rst_halted", {31'b0, halted}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_lr", lr_out, 32'h0);
    chk("arst_halted", {31'b0, halted}, 32'h0);
    chk("arst_ovf", {31'b0, ras_overflow}, 32'h0);
    chk("arst_uflow", {31'b0, ras_underflow}, 32'h0);
    chk("arst_ready", {31'b0, ready_out}, 32'h1);
    idle();
    reset = 1'b0;
    issue(OP_RET, 4'd0, 4'd0, 32'hC00, 32'h0077, 32'h0);
    chk("post_rst_ret_pc", pc_out, 32'h76);
    chk("post_rst_uflow", {31'b0, ras_underflow}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
